bus_arbiter: RTL and testbench

- Two-master arbiter for the shared system bus (urom/sram/uart/eram slaves, one-hot ce {eram,uart,sram,urom}).
- Master 0 is the core LSU; master 1 is a secondary requester (DMA / UART boot loader).
- Serialises transactions, drives the single slave-side req/gnt handshake, completes zero-latency slaves internally, and returns registered read data and a one-cycle grant to the owning master.

---
 rtl/bus_arbiter_if.sv | 47 ++++
 rtl/bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bundle of the two master request ports and the shared slave-side bus of bus_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and slaves' view.
interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_we;
  logic [1:0]  m0_hb;
  logic [3:0]  m0_ce;
  logic        m0_gnt;
  logic [31:0] m0_rdata;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_we;
  logic [1:0]  m1_hb;
  logic [3:0]  m1_ce;
  logic        m1_gnt;
  logic [31:0] m1_rdata;

  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic        bus_we_o;
  logic [1:0]  bus_hb_o;
  logic [3:0]  bus_ce_o;
  logic [31:0] bus_rdata_i;
  logic        bus_gnt_i;
  logic        bus_err_o;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we, m0_hb, m0_ce,
    input  m1_req, m1_addr, m1_wdata, m1_we, m1_hb, m1_ce,
    output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    output bus_req_o, bus_addr_o, bus_data_o, bus_we_o, bus_hb_o, bus_ce_o, bus_err_o,
    input  bus_rdata_i, bus_gnt_i
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we, m0_hb, m0_ce,
    output m1_req, m1_addr, m1_wdata, m1_we, m1_hb, m1_ce,
    input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    input  bus_req_o, bus_addr_o, bus_data_o, bus_we_o, bus_hb_o, bus_ce_o, bus_err_o,
    output bus_rdata_i, bus_gnt_i
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter: IDLE -> ACTIVE -> RELEASE per transaction, one-cycle grant.
// Optional macro BUS_TIMEOUT_EN adds a forced completion with bus_err_o after TIMEOUT_CYCLES.
module bus_arbiter #(
   parameter logic [3:0]  COMB_MASK      = 4'b0101,
   parameter bit          FIXED_PRIO     = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic            sysclk,
   input  logic            rst_n,
   bus_arbiter_if.slave    bus
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACTIVE  = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t      state;
   logic        owner;
   logic        last_owner;
   logic        m0_gnt_q;
   logic        m1_gnt_q;
   logic [31:0] m0_rdata_q;
   logic [31:0] m1_rdata_q;
   logic        err_q;

   // Owner's payload, selected by the latched owner.
   logic [31:0] own_addr;
   logic [31:0] own_wdata;
   logic        own_we;
   logic [1:0]  own_hb;
   logic [3:0]  own_ce;

   assign own_addr  = owner ? bus.m1_addr  : bus.m0_addr;
   assign own_wdata = owner ? bus.m1_wdata : bus.m0_wdata;
   assign own_we    = owner ? bus.m1_we    : bus.m0_we;
   assign own_hb    = owner ? bus.m1_hb    : bus.m0_hb;
   assign own_ce    = owner ? bus.m1_ce    : bus.m0_ce;

   logic active;
   assign active = (state == ST_ACTIVE);

   always_comb begin
      // NOTE: every output gets a value before the conditional, so no latch is inferred.
      bus.bus_req_o  = 1'b0;
      bus.bus_addr_o = '0;
      bus.bus_data_o = '0;
      bus.bus_we_o   = 1'b0;
      bus.bus_hb_o   = '0;
      bus.bus_ce_o   = '0;
      if (active) begin
         bus.bus_req_o  = 1'b1;
         bus.bus_addr_o = own_addr;
         bus.bus_data_o = own_wdata;
         bus.bus_we_o   = own_we;
         bus.bus_hb_o   = own_hb;
         bus.bus_ce_o   = own_ce;
      end
   end

   // Zero-latency slaves and the no-slave case complete without waiting for bus_gnt_i.
   logic comb_hit;
   logic no_slave;
   logic done;
   assign comb_hit = |(own_ce & COMB_MASK);
   assign no_slave = (own_ce == 4'b0000);
   assign done     = comb_hit | no_slave | bus.bus_gnt_i;

   logic tmo_hit;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] tmo_cnt;

   // Held at zero outside ACTIVE, so it starts from zero on every entry.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (!active) begin
         tmo_cnt <= '0;
      end else if (!done) begin
         tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
   end

   assign tmo_hit = active && !done && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
   assign tmo_hit = 1'b0;
`endif

   logic [31:0] cap_data;
   assign cap_data = tmo_hit  ? 32'hDEAD_BEEF :
                     no_slave ? 32'h0000_0000 : bus.bus_rdata_i;

   // Both requesting: fixed priority picks m0, otherwise the master not served last.
   logic pick;
   assign pick = (bus.m0_req && bus.m1_req) ? (FIXED_PRIO ? 1'b0 : ~last_owner) : bus.m1_req;

   always_ff @(posedge sysclk or negedge rst_n) begin
      // NOTE: the read-data registers are reset too, since masters may sample them right after reset.
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         m0_gnt_q   <= 1'b0;
         m1_gnt_q   <= 1'b0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         err_q      <= 1'b0;
      end else begin
         m0_gnt_q <= 1'b0;
         m1_gnt_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (bus.m0_req || bus.m1_req) begin
                  owner <= pick;
                  state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (done || tmo_hit) begin
                  if (owner) begin
                     m1_rdata_q <= cap_data;
                     m1_gnt_q   <= 1'b1;
                  end else begin
                     m0_rdata_q <= cap_data;
                     m0_gnt_q   <= 1'b1;
                  end
                  err_q <= tmo_hit;
                  state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               last_owner <= owner;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.m0_gnt    = m0_gnt_q;
   assign bus.m1_gnt    = m1_gnt_q;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rdata  = m1_rdata_q;
   assign bus.bus_err_o = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations, then
// random traffic compared every cycle against a transaction-level model.
module tb_bus_arbiter;
   localparam logic [3:0] COMB_MASK = 4'b0101;
   localparam int         TMO       = 4;
`ifdef BUS_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic sysclk = 1'b0;
   logic rst_n  = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   bus_arbiter_if bif ();

   bus_arbiter #(
      .COMB_MASK     (COMB_MASK),
      .FIXED_PRIO    (1'b0),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sysclk(sysclk),
      .rst_n (rst_n),
      .bus   (bif.slave)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // m_busy: a transaction is in flight; m_active: still on the bus (else in its grant cycle).
   bit          m_busy, m_active, m_owner, m_last, m_tmo;
   int          m_age;
   logic [31:0] m_rd [2];

   task automatic model_reset();
      m_busy = 0; m_active = 0; m_owner = 0; m_last = 1; m_tmo = 0; m_age = 0;
      m_rd[0] = '0; m_rd[1] = '0;
   endtask

   // Called at a rising edge with the inputs that were present during the cycle just ended.
   task automatic model_step();
      logic [3:0] ce;
      if (!m_busy) begin
         if (bif.m0_req || bif.m1_req) begin
            if (bif.m0_req && bif.m1_req) m_owner = (m_last == 0);
            else                          m_owner = bif.m1_req;
            m_busy = 1; m_active = 1; m_age = 0; m_tmo = 0;
         end
      end else if (m_active) begin
         ce = m_owner ? bif.m1_ce : bif.m0_ce;
         if ((ce & COMB_MASK) != 0) begin
            m_rd[m_owner] = bif.bus_rdata_i; m_active = 0;
         end else if (ce == 0) begin
            m_rd[m_owner] = 32'h0; m_active = 0;
         end else if (bif.bus_gnt_i) begin
            m_rd[m_owner] = bif.bus_rdata_i; m_active = 0;
         end else if (TMO_ON && m_age == TMO) begin
            m_rd[m_owner] = 32'hDEAD_BEEF; m_active = 0; m_tmo = 1;
         end else begin
            m_age++;
         end
      end else begin
         m_busy = 0; m_last = m_owner; m_tmo = 0;
      end
   endtask

   task automatic compare();
      logic        on;
      logic [31:0] ea, ed;
      logic [6:0]  ectl;
      logic [1:0]  eg;
      on   = m_busy && m_active;
      ea   = '0; ed = '0; ectl = '0; eg = '0;
      if (on) begin
         ea   = m_owner ? bif.m1_addr  : bif.m0_addr;
         ed   = m_owner ? bif.m1_wdata : bif.m0_wdata;
         ectl = m_owner ? {bif.m1_we, bif.m1_hb, bif.m1_ce} : {bif.m0_we, bif.m0_hb, bif.m0_ce};
      end
      if (m_busy && !m_active) eg = m_owner ? 2'b10 : 2'b01;
      check("bus_req",  bif.bus_req_o, on);
      check("bus_addr", bif.bus_addr_o, ea);
      check("bus_data", bif.bus_data_o, ed);
      check("bus_ctl",  {bif.bus_we_o, bif.bus_hb_o, bif.bus_ce_o}, ectl);
      check("gnt",      {bif.m1_gnt, bif.m0_gnt}, eg);
      check("m0_rdata", bif.m0_rdata, m_rd[0]);
      check("m1_rdata", bif.m1_rdata, m_rd[1]);
      check("bus_err",  bif.bus_err_o, m_busy && !m_active && m_tmo);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge sysclk);
         if (!rst_n) model_reset();
         else        model_step();
         @(negedge sysclk);
         if (!rst_n) model_reset();
         compare();
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge sysclk);
   endtask

   task automatic idle_inputs();
      bif.m0_req = 0; bif.m0_addr = '0; bif.m0_wdata = '0; bif.m0_we = 0; bif.m0_hb = '0; bif.m0_ce = '0;
      bif.m1_req = 0; bif.m1_addr = '0; bif.m1_wdata = '0; bif.m1_we = 0; bif.m1_hb = '0; bif.m1_ce = '0;
      bif.bus_rdata_i = '0; bif.bus_gnt_i = 0;
   endtask

   task automatic new_req(input int m);
      logic [3:0] ce;
      int         sel;
      sel = $urandom_range(9);
      case (sel)
         0, 1:    ce = 4'b0001;
         2, 3:    ce = 4'b0100;
         4, 5, 9: ce = 4'b0010;
         6, 7:    ce = 4'b1000;
         default: ce = 4'b0000;
      endcase
      if (m == 0) begin
         bif.m0_addr = $urandom(); bif.m0_wdata = $urandom(); bif.m0_we = 1'($urandom_range(1));
         bif.m0_hb = 2'($urandom_range(3)); bif.m0_ce = ce; bif.m0_req = 1;
      end else begin
         bif.m1_addr = $urandom(); bif.m1_wdata = $urandom(); bif.m1_we = 1'($urandom_range(1));
         bif.m1_hb = 2'($urandom_range(3)); bif.m1_ce = ce; bif.m1_req = 1;
      end
   endtask

   int order[$];
   int got;

   initial begin
      idle_inputs();
      repeat (3) @(posedge sysclk);
      at_neg();
      check("rst_req", bif.bus_req_o, 0);
      check("rst_gnt", {bif.m1_gnt, bif.m0_gnt}, 0);
      check("rst_rd0", bif.m0_rdata, 0);
      check("rst_rd1", bif.m1_rdata, 0);
      step();
      rst_n = 1;

      // m0 read from urom
      step();
      bif.m0_addr = 32'h10; bif.m0_ce = 4'b0001; bif.m0_we = 0; bif.m0_hb = 2'b11;
      bif.bus_rdata_i = 32'h1234_5678; bif.m0_req = 1;
      step(); at_neg();
      check("t2_req", bif.bus_req_o, 1);
      check("t2_addr", bif.bus_addr_o, 32'h10);
      check("t2_ce", bif.bus_ce_o, 4'b0001);
      check("t2_gnt_early", bif.m0_gnt, 0);
      step(); bif.m0_req = 0; at_neg();
      check("t2_gnt", bif.m0_gnt, 1);
      check("t2_req_drop", bif.bus_req_o, 0);
      check("t2_rdata", bif.m0_rdata, 32'h1234_5678);
      step(); at_neg();
      check("t2_gnt_pulse", bif.m0_gnt, 0);

      // m1 write to sram, slave grant in the third ACTIVE cycle
      step();
      bif.m1_addr = 32'h200; bif.m1_wdata = 32'hA5A5_A5A5; bif.m1_we = 1; bif.m1_hb = 2'b11;
      bif.m1_ce = 4'b0010; bif.bus_gnt_i = 0; bif.bus_rdata_i = 32'h0BAD_F00D; bif.m1_req = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 2) bif.bus_gnt_i = 1;
         at_neg();
         check("t3_data", bif.bus_data_o, 32'hA5A5_A5A5);
         check("t3_we", bif.bus_we_o, 1);
         check("t3_gnt_early", bif.m1_gnt, 0);
      end
      step(); bif.bus_gnt_i = 0; bif.m1_req = 0; at_neg();
      check("t3_m1_gnt", bif.m1_gnt, 1);
      check("t3_m0_gnt", bif.m0_gnt, 0);
      check("t3_m0_rdata", bif.m0_rdata, 32'h1234_5678);
      check("t3_m1_rdata", bif.m1_rdata, 32'h0BAD_F00D);

      // round-robin with both masters requesting continuously
      step();
      bif.m0_ce = 4'b0001; bif.m0_we = 0; bif.m1_ce = 4'b0100; bif.m1_we = 0;
      bif.bus_rdata_i = 32'h5555_AAAA; bif.m0_req = 1; bif.m1_req = 1;
      for (int k = 0; k < 30 && order.size() < 4; k++) begin
         step();
         if (bif.m0_gnt) order.push_back(0);
         if (bif.m1_gnt) order.push_back(1);
         if (order.size() >= 4) begin bif.m0_req = 0; bif.m1_req = 0; end
      end
      bif.m0_req = 0; bif.m1_req = 0;
      check("t4_count", order.size(), 4);
      for (int i = 0; i < order.size(); i++) check("t4_order", order[i], i % 2);

      // no slave selected
      step(); step();
      bif.m0_ce = 4'b0000; bif.bus_rdata_i = 32'hFFFF_FFFF; bif.m0_req = 1;
      step(); at_neg();
      check("t5_req", bif.bus_req_o, 1);
      check("t5_ce", bif.bus_ce_o, 0);
      step(); bif.m0_req = 0; at_neg();
      check("t5_gnt", bif.m0_gnt, 1);
      check("t5_rdata", bif.m0_rdata, 0);
      check("t5_err", bif.bus_err_o, 0);

      // reset during an eram access
      step(); step();
      bif.m1_ce = 4'b1000; bif.m1_we = 0; bif.bus_gnt_i = 0; bif.m1_req = 1;
      step(); at_neg();
      check("t6_req", bif.bus_req_o, 1);
      #1 rst_n = 0;
      #1;
      check("t6_req_rst", bif.bus_req_o, 0);
      check("t6_gnt_rst", {bif.m1_gnt, bif.m0_gnt}, 0);
      check("t6_rd1_rst", bif.m1_rdata, 0);
      step(); step();
      bif.m0_ce = 4'b0001; bif.m0_req = 1; bif.m1_ce = 4'b0100;
      rst_n = 1;
      got = 0;
      for (int k = 0; k < 8 && got == 0; k++) begin
         step();
         if (bif.m0_gnt || bif.m1_gnt) begin
            check("t6_first", {bif.m1_gnt, bif.m0_gnt}, 2'b01);
            got = 1;
            bif.m0_req = 0; bif.m1_req = 0;
         end
      end
      bif.m0_req = 0; bif.m1_req = 0;
      check("t6_got", got, 1);

`ifdef BUS_TIMEOUT_EN
      // eram access that the slave never acknowledges
      step(); step();
      bif.m0_ce = 4'b1000; bif.bus_gnt_i = 0; bif.m0_req = 1;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         step();
         if (bif.m0_gnt) begin
            check("t7_err", bif.bus_err_o, 1);
            check("t7_rdata", bif.m0_rdata, 32'hDEAD_BEEF);
            check("t7_latency", k, TMO + 1);
            got = 1;
            bif.m0_req = 0;
         end
      end
      bif.m0_req = 0;
      check("t7_got", got, 1);
`endif

      // random traffic, checked by the model every cycle
      step(); step();
      for (int c = 0; c < 3000; c++) begin
         step();
         bif.bus_rdata_i = $urandom();
         bif.bus_gnt_i   = ($urandom_range(2) == 0);
         if (c == 1500) rst_n = 0;
         if (c == 1503) rst_n = 1;
         if (bif.m0_gnt) begin
            if ($urandom_range(3) == 0) bif.m0_req = 0;
            else                        new_req(0);
         end else if (!bif.m0_req && $urandom_range(2) == 0) begin
            new_req(0);
         end
         if (bif.m1_gnt) begin
            if ($urandom_range(3) == 0) bif.m1_req = 0;
            else                        new_req(1);
         end else if (!bif.m1_req && $urandom_range(2) == 0) begin
            new_req(1);
         end
      end
      step(); at_neg();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
